// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. Computes (A - B) mod 2^WIDTH one bit per
//   clock, LSB first, and reports the final borrow-out (A < B).
//   A start in IDLE latches both operands. The block then spends WIDTH cycles
//   in RUN and one cycle in DONE, and returns to IDLE. The result stays on
//   o_diff/o_borrow until the next operation completes or until reset.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   i_start   in   1      start request, accepted only in IDLE
//   i_a       in   WIDTH  minuend, sampled on the accepting edge
//   i_b       in   WIDTH  subtrahend, sampled on the accepting edge
//   o_busy    out  1      high in RUN and DONE
//   o_done    out  1      one-cycle pulse, result valid from this cycle
//   o_diff    out  WIDTH  (A - B) mod 2^WIDTH
//   o_borrow  out  1      1 when A < B
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;

  // Full-subtractor cell on the current LSBs.
  logic bit_d;
  logic br_next;

  always_comb begin
    bit_d   = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_next = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          a_sr_d  = i_a;
          b_sr_d  = i_b;
          d_sr_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        d_sr_d = (d_sr_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish from the next-state values so the last bit and borrow are included.
          diff_d   = d_sr_d;
          borrow_d = br_next;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor (WIDTH=8). Each accepted start
//   pushes the golden difference, borrow and due cycle. Each o_done pops one
//   entry and compares against it.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_diff   (o_diff),
    .o_borrow (o_borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    int unsigned  due;
  } exp_t;

  exp_t         sb[$];
  int unsigned  cyc = 0;
  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_borrow = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("diff", 32'(o_diff), 32'(e.diff));
        check_eq("borrow", 32'(o_borrow), 32'(e.borrow));
        check_eq("latency", cyc, e.due);
        last_diff   = e.diff;
        last_borrow = e.borrow;
      end
    end
  end

  // Returns on a falling edge where the DUT is idle.
  task automatic wait_idle();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) check_eq("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issues one operation. With harass set, i_start stays high with junk
  // operands through RUN and DONE, and is released in the following IDLE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit harass);
    exp_t e;
    wait_idle();
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    e.diff   = a - b;
    e.borrow = (a < b);
    e.due    = cyc + 1 + W;
    sb.push_back(e);
    @(posedge clk);
    if (harass) begin
      for (int i = 0; i < int'(W) + 1; i++) begin
        @(negedge clk);
        i_start = 1'b1;
        i_a     = W'($urandom);
        i_b     = W'($urandom);
      end
      @(negedge clk);
      i_start = 1'b0;
    end else begin
      @(negedge clk);
      i_start = 1'b0;
      i_a     = W'($urandom);
      i_b     = W'($urandom);
    end
  endtask

  initial begin
    int unsigned n;
    rst     = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_diff", 32'(o_diff), 32'd0);
    check_eq("rst_borrow", 32'(o_borrow), 32'd0);
    rst = 1'b0;

    // Directed vectors.
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'h03, 8'h05, 1'b0);
    do_op(8'h00, 8'hFF, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0);
    do_op(8'h80, 8'h00, 1'b0);

    // Result must hold while idle.
    wait_idle();
    repeat (4) @(negedge clk);
    check_eq("hold_diff", 32'(o_diff), 32'(last_diff));
    check_eq("hold_borrow", 32'(o_borrow), 32'(last_borrow));

    // Starts and operand changes during RUN and DONE are ignored.
    do_op(8'h37, 8'hC4, 1'b1);
    do_op(8'hA0, 8'h0F, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("no_extra_op", 32'(o_busy), 32'd0);

    // Reset 4 cycles after start aborts the op; a start during reset is dropped.
    do_op(8'h5A, 8'h21, 1'b0);
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    i_start = 1'b1;
    i_a     = 8'h11;
    i_b     = 8'h22;
    @(negedge clk);
    sb.delete();
    check_eq("abort_busy", 32'(o_busy), 32'd0);
    check_eq("abort_done", 32'(o_done), 32'd0);
    check_eq("abort_diff", 32'(o_diff), 32'd0);
    check_eq("abort_borrow", 32'(o_borrow), 32'd0);
    rst     = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    check_eq("rst_start_dropped", 32'(o_busy), 32'd0);
    do_op(8'h5A, 8'h21, 1'b0);

    // Back-to-back random sweep.
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'b0);
    end
    do_op(8'h00, 8'h00, 1'b0);
    do_op(8'h00, 8'h01, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
